// File: rtl/d_latch_bank_if.sv
// Bus bundle for d_latch_bank: per-channel data/enables in, committed snapshot out.
// hold_cnt_out exists only when D_LATCH_BANK_HOLD_CNT_EN is defined.
interface d_latch_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS*WIDTH-1:0] d_in;
    logic [CHANNELS-1:0]       en_in;
    logic                      commit_in;
    logic [CHANNELS*WIDTH-1:0] q_out;
    logic [CHANNELS-1:0]       dirty_out;
    logic                      commit_done_out;
`ifdef D_LATCH_BANK_HOLD_CNT_EN
    logic [CHANNELS*CNT_W-1:0] hold_cnt_out;

    modport master (output d_in, en_in, commit_in,
                    input  q_out, dirty_out, commit_done_out, hold_cnt_out);
    modport slave  (input  d_in, en_in, commit_in,
                    output q_out, dirty_out, commit_done_out, hold_cnt_out);
`else
    modport master (output d_in, en_in, commit_in,
                    input  q_out, dirty_out, commit_done_out);
    modport slave  (input  d_in, en_in, commit_in,
                    output q_out, dirty_out, commit_done_out);
`endif

    if (WIDTH < 1 || CHANNELS < 1 || CNT_W < 1) begin : g_bad_params
        $error("d_latch_bank_if: WIDTH, CHANNELS and CNT_W must all be >= 1");
    end
endinterface

// File: rtl/d_latch_bank.sv
// Multi-channel shadow/commit register bank emulating D latches synchronously.
// Optional per-channel hold counters enabled by defining D_LATCH_BANK_HOLD_CNT_EN.
module d_latch_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int CNT_W    = 8
) (
    input logic           clk_in,
    input logic           rst_in,
    d_latch_bank_if.slave bus
);
    localparam int DW = CHANNELS * WIDTH;

    logic [DW-1:0]       r_shadow;
    logic [DW-1:0]       r_q;
    logic [CHANNELS-1:0] r_en_prev;
    logic [CHANNELS-1:0] r_dirty;
    logic                r_commit_done;
    logic [CHANNELS-1:0] w_capture;

    // Edge mode only captures when the previous cycle's enable was low.
    assign w_capture = bus.en_in & ((MODE == 0) ? {CHANNELS{1'b1}} : ~r_en_prev);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the shadow bank is plain flops, not RAM, and its reset value is
            // observable through a commit, so it is cleared with everything else.
            r_shadow      <= '0;
            r_q           <= '0;
            r_en_prev     <= '0;
            r_dirty       <= '0;
            r_commit_done <= 1'b0;
        end else begin
            r_en_prev     <= bus.en_in;
            r_commit_done <= bus.commit_in;
            if (bus.commit_in) begin
                // NOTE: non-blocking assignment makes r_q take the pre-edge shadow,
                // so a capture in the commit cycle waits for the next commit.
                r_q     <= r_shadow;
                r_dirty <= w_capture;
            end else begin
                r_dirty <= r_dirty | w_capture;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_capture[k]) begin
                    r_shadow[k*WIDTH +: WIDTH] <= bus.d_in[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.q_out           = r_q;
    assign bus.dirty_out       = r_dirty;
    assign bus.commit_done_out = r_commit_done;

`ifdef D_LATCH_BANK_HOLD_CNT_EN
    logic [CHANNELS*CNT_W-1:0] r_hold;

    // Saturating age counters; commits deliberately leave them alone.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hold <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_capture[k]) begin
                    r_hold[k*CNT_W +: CNT_W] <= '0;
                end else if (r_hold[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    r_hold[k*CNT_W +: CNT_W] <= r_hold[k*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

    assign bus.hold_cnt_out = r_hold;
`endif

    if (WIDTH < 1 || CHANNELS < 1 || CNT_W < 1 || MODE < 0 || MODE > 1) begin : g_bad_params
        $error("d_latch_bank: illegal parameter combination");
    end
endmodule
